// File: rtl/input_debounce_pkg.sv
// input_debounce_pkg
//   Shared definitions for the input_debounce_cpu slice:
//   - register offsets (multiplied by Address_Wording and added to BaseAddress)
//   - per-bit debounce state record (sized for the largest supported build)
//   - reg_addr(): absolute bus address of a register offset
package input_debounce_pkg;

   localparam int unsigned REG_PERIOD = 0;
   localparam int unsigned REG_BYPASS = 1;
   localparam int unsigned REG_SYNCED = 2;
   localparam int unsigned REG_CLEAN  = 3;
   localparam int unsigned REG_CHANGE = 4;

   localparam int unsigned SYNC_MAX = 8;
   localparam int unsigned CNT_MAX  = 32;

   typedef struct packed {
      logic [SYNC_MAX-1:0] sync;
      logic                clean;
      logic [CNT_MAX-1:0]  cnt;
   } bit_state_t;

   function automatic logic [31:0] reg_addr(input int unsigned base,
                                            input int unsigned stride,
                                            input int unsigned offset);
      return 32'(base + offset * stride);
   endfunction

endpackage

// File: rtl/input_debounce_cpu_debounce_bit.sv
// debounce_bit
//   One input bit: SYNC_STAGES-flop synchroniser, qualification counter and
//   clean flop. The counter only advances on tick_i while the synced value
//   differs from clean; any return to the clean value clears it.
//   Optional macro INPUT_DEBOUNCE_CHANGE_EN adds change_o (one-cycle pulse on
//   every clean transition, registered on the same edge as clean).
// Ports:
//   clk_i, reset_i  clock, synchronous active-low reset
//   raw_i           asynchronous pin
//   tick_i          prescaler tick
//   period_i        qualification period in ticks (0 = pass-through)
//   bypass_i        pass-through for this bit
//   synced_o        synchroniser output
//   clean_o         debounced output
//   change_o        (macro only) transition pulse
module debounce_bit #(
   parameter int unsigned data_width  = 8,
   parameter int unsigned SYNC_STAGES = 2
)(
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  raw_i,
   input  logic                  tick_i,
   input  logic [data_width-1:0] period_i,
   input  logic                  bypass_i,
   output logic                  synced_o,
   output logic                  clean_o
`ifdef INPUT_DEBOUNCE_CHANGE_EN
   ,output logic                 change_o
`endif
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [data_width-1:0]  cnt_q;
   logic [data_width-1:0]  cnt_d;
   logic                   clean_d;

   assign synced_o = sync_q[SYNC_STAGES-1];

   // The >= compare lets a shortened period take effect on the next tick
   // without the counter ever having to wrap past the new limit.
   always_comb begin
      clean_d = clean_o;
      cnt_d   = cnt_q;
      if (bypass_i || (period_i == '0)) begin
         clean_d = synced_o;
         cnt_d   = '0;
      end else if (synced_o == clean_o) begin
         cnt_d = '0;
      end else if (tick_i) begin
         if (cnt_q >= (period_i - data_width'(1))) begin
            clean_d = synced_o;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q + data_width'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         sync_q   <= '0;
         cnt_q    <= '0;
         clean_o  <= 1'b0;
`ifdef INPUT_DEBOUNCE_CHANGE_EN
         change_o <= 1'b0;
`endif
      end else begin
         sync_q   <= {sync_q[SYNC_STAGES-2:0], raw_i};
         cnt_q    <= cnt_d;
         clean_o  <= clean_d;
`ifdef INPUT_DEBOUNCE_CHANGE_EN
         change_o <= clean_d ^ clean_o;
`endif
      end
   end

endmodule

// File: rtl/input_debounce_cpu.sv
// input_debounce_cpu
//   Bus-mapped input conditioner: synchronises and debounces data_width raw
//   pins and presents the clean field on clean_o (feeds the IO controller's
//   ex_data_i). Registers at BaseAddress + offset*Address_Wording:
//     0 Period (R/W), 1 Bypass mask (R/W), 2 Synced raw (R), 3 Clean (R),
//     4 Change flags (R, clear-on-read; only with INPUT_DEBOUNCE_CHANGE_EN).
//   Optional macro INPUT_DEBOUNCE_CHANGE_EN adds change_o and register 4.
// Ports:
//   clk_i, reset_i      clock, synchronous active-low reset
//   address_i, data_i   CPU address / write data
//   rd_wr_i             0 = read, 1 = write
//   data_o              registered read data (holds during writes)
//   take_controlr_o     read decode hit, take_controlw_o write decode hit
//   raw_i               asynchronous pins
//   clean_o             debounced bits
//   change_o            (macro only) per-bit transition pulse
module input_debounce_cpu
   import input_debounce_pkg::*;
#(
   parameter int unsigned BaseAddress     = 0,
   parameter int unsigned address_width   = 16,
   parameter int unsigned data_width      = 8,
   parameter int unsigned Address_Wording = 1,
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned PRESCALE        = 1000,
   parameter int unsigned DEFAULT_PERIOD  = 4
)(
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic [address_width-1:0] address_i,
   input  logic [data_width-1:0]    data_i,
   output logic [data_width-1:0]    data_o,
   input  logic                     rd_wr_i,
   output logic                     take_controlr_o,
   output logic                     take_controlw_o,
   input  logic [data_width-1:0]    raw_i,
   output logic [data_width-1:0]    clean_o
`ifdef INPUT_DEBOUNCE_CHANGE_EN
   ,output logic [data_width-1:0]   change_o
`endif
);

   localparam logic [address_width-1:0] ADDR_PERIOD =
      address_width'(reg_addr(BaseAddress, Address_Wording, REG_PERIOD));
   localparam logic [address_width-1:0] ADDR_BYPASS =
      address_width'(reg_addr(BaseAddress, Address_Wording, REG_BYPASS));
   localparam logic [address_width-1:0] ADDR_SYNCED =
      address_width'(reg_addr(BaseAddress, Address_Wording, REG_SYNCED));
   localparam logic [address_width-1:0] ADDR_CLEAN =
      address_width'(reg_addr(BaseAddress, Address_Wording, REG_CLEAN));
`ifdef INPUT_DEBOUNCE_CHANGE_EN
   localparam logic [address_width-1:0] ADDR_CHANGE =
      address_width'(reg_addr(BaseAddress, Address_Wording, REG_CHANGE));
`endif

   localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   logic [PS_W-1:0]       ps_q;
   logic                  tick;
   logic [data_width-1:0] period_q;
   logic [data_width-1:0] bypass_q;
   logic [data_width-1:0] synced;
   logic                  hit_period;
   logic                  hit_bypass;
   logic                  rd_hit;
   logic [data_width-1:0] rd_data;
`ifdef INPUT_DEBOUNCE_CHANGE_EN
   logic                  hit_change;
   logic [data_width-1:0] flags_q;
`endif

   // Prescaler: 0..PRESCALE-1, tick on the last count (every cycle if 1).
   assign tick = (ps_q == PS_W'(PRESCALE - 1));

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         ps_q <= '0;
      end else begin
         ps_q <= tick ? '0 : (ps_q + PS_W'(1));
      end
   end

   assign hit_period = (address_i == ADDR_PERIOD);
   assign hit_bypass = (address_i == ADDR_BYPASS);
`ifdef INPUT_DEBOUNCE_CHANGE_EN
   assign hit_change = (address_i == ADDR_CHANGE);
`endif

   always_comb begin
      rd_hit  = 1'b1;
      rd_data = '0;
      if (hit_period) begin
         rd_data = period_q;
      end else if (hit_bypass) begin
         rd_data = bypass_q;
      end else if (address_i == ADDR_SYNCED) begin
         rd_data = synced;
      end else if (address_i == ADDR_CLEAN) begin
         rd_data = clean_o;
`ifdef INPUT_DEBOUNCE_CHANGE_EN
      end else if (hit_change) begin
         rd_data = flags_q;
`endif
      end else begin
         rd_hit = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         data_o          <= '0;
         take_controlr_o <= 1'b0;
         take_controlw_o <= 1'b0;
         period_q        <= data_width'(DEFAULT_PERIOD);
         bypass_q        <= '0;
      end else begin
         if (!rd_wr_i) begin
            data_o          <= rd_data;
            take_controlr_o <= rd_hit;
         end
         take_controlw_o <= rd_wr_i && (hit_period || hit_bypass);
         if (rd_wr_i && hit_period) begin
            period_q <= data_i;
         end
         if (rd_wr_i && hit_bypass) begin
            bypass_q <= data_i;
         end
      end
   end

`ifdef INPUT_DEBOUNCE_CHANGE_EN
   // Clear-on-read applies before OR-ing in new pulses so a same-edge change survives.
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         flags_q <= '0;
      end else begin
         flags_q <= ((!rd_wr_i && hit_change) ? '0 : flags_q) | change_o;
      end
   end
`endif

   for (genvar b = 0; b < data_width; b++) begin : g_bit
      debounce_bit #(
         .data_width  (data_width),
         .SYNC_STAGES (SYNC_STAGES)
      ) u_bit (
         .clk_i    (clk_i),
         .reset_i  (reset_i),
         .raw_i    (raw_i[b]),
         .tick_i   (tick),
         .period_i (period_q),
         .bypass_i (bypass_q[b]),
         .synced_o (synced[b]),
         .clean_o  (clean_o[b])
`ifdef INPUT_DEBOUNCE_CHANGE_EN
         ,.change_o (change_o[b])
`endif
      );
   end

endmodule

// File: tb/tb_input_debounce_cpu.sv
module tb_input_debounce_cpu;

   localparam int unsigned AW     = 16;
   localparam int unsigned DW     = 8;
   localparam int unsigned BASE   = 'h40;
   localparam int unsigned STRIDE = 2;
   localparam int unsigned SYNC   = 2;
   localparam int unsigned PRE    = 1;
   localparam int unsigned DEFP   = 4;
   localparam logic [AW-1:0] IDLE = 16'h0000;

   logic          clk = 1'b0;
   logic          reset_i;
   logic [AW-1:0] address_i;
   logic [DW-1:0] data_i;
   logic [DW-1:0] data_o;
   logic          rd_wr_i;
   logic          take_controlr_o;
   logic          take_controlw_o;
   logic [DW-1:0] raw_i;
   logic [DW-1:0] clean_o;
`ifdef INPUT_DEBOUNCE_CHANGE_EN
   logic [DW-1:0] change_o;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   input_debounce_cpu #(
      .BaseAddress     (BASE),
      .address_width   (AW),
      .data_width      (DW),
      .Address_Wording (STRIDE),
      .SYNC_STAGES     (SYNC),
      .PRESCALE        (PRE),
      .DEFAULT_PERIOD  (DEFP)
   ) dut (
      .clk_i           (clk),
      .reset_i         (reset_i),
      .address_i       (address_i),
      .data_i          (data_i),
      .data_o          (data_o),
      .rd_wr_i         (rd_wr_i),
      .take_controlr_o (take_controlr_o),
      .take_controlw_o (take_controlw_o),
      .raw_i           (raw_i),
      .clean_o         (clean_o)
`ifdef INPUT_DEBOUNCE_CHANGE_EN
      ,.change_o       (change_o)
`endif
   );

   // ---------------- reference model ----------------
   logic [DW-1:0] sync_m [SYNC];
   int            run_m  [DW];   // consecutive mismatching ticks seen
   int            ps_m;
   logic [DW-1:0] clean_m, change_m, flags_m, period_m, bypass_m, data_m;
   logic          tcr_m, tcw_m;

   function automatic logic [AW-1:0] addr_of(input int unsigned k);
      return AW'(BASE + k * STRIDE);
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < SYNC; i++) sync_m[i] = '0;
      for (int b = 0; b < DW; b++) run_m[b] = 0;
      ps_m = 0; clean_m = '0; change_m = '0; flags_m = '0;
      period_m = DW'(DEFP); bypass_m = '0; data_m = '0; tcr_m = 1'b0; tcw_m = 1'b0;
   endtask

   // Next state from the inputs present just before the coming edge.
   task automatic model_edge();
      logic [DW-1:0] synced, nclean, rdv;
      logic tick, hit, clr;
      int k;
      if (reset_i == 1'b0) begin
         model_clear();
         return;
      end
      tick = (ps_m == PRE - 1);
      ps_m = tick ? 0 : ps_m + 1;
      synced = sync_m[SYNC-1];
      nclean = clean_m;
      for (int b = 0; b < DW; b++) begin
         if (bypass_m[b] || period_m == 0) begin
            nclean[b] = synced[b]; run_m[b] = 0;
         end else if (synced[b] == clean_m[b]) begin
            run_m[b] = 0;
         end else if (tick) begin
            run_m[b] = run_m[b] + 1;
            if (run_m[b] >= int'(period_m)) begin
               nclean[b] = synced[b]; run_m[b] = 0;
            end
         end
      end
      k = -1;
      for (int i = 0; i < 6; i++) if (address_i == addr_of(i)) k = i;
      hit = 1'b1;
      case (k)
         0: rdv = period_m;
         1: rdv = bypass_m;
         2: rdv = synced;
         3: rdv = clean_m;
`ifdef INPUT_DEBOUNCE_CHANGE_EN
         4: rdv = flags_m;
`endif
         default: begin rdv = '0; hit = 1'b0; end
      endcase
      clr = 1'b0;
      if (!rd_wr_i) begin
         data_m = rdv; tcr_m = hit; clr = hit && (k == 4);
      end
      tcw_m = rd_wr_i && (k == 0 || k == 1);
      if (rd_wr_i && k == 0) period_m = data_i;
      if (rd_wr_i && k == 1) bypass_m = data_i;
      flags_m  = (clr ? '0 : flags_m) | change_m;
      change_m = nclean ^ clean_m;
      clean_m  = nclean;
      for (int i = SYNC - 1; i > 0; i--) sync_m[i] = sync_m[i-1];
      sync_m[0] = raw_i;
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      check("clean_o", clean_o, clean_m);
      check("data_o", data_o, data_m);
      check("take_controlr_o", take_controlr_o, tcr_m);
      check("take_controlw_o", take_controlw_o, tcw_m);
`ifdef INPUT_DEBOUNCE_CHANGE_EN
      check("change_o", change_o, change_m);
`endif
   endtask

   task automatic wr(input int unsigned k, input logic [DW-1:0] v);
      address_i = addr_of(k); data_i = v; rd_wr_i = 1'b1;
      step();
      rd_wr_i = 1'b0; address_i = IDLE;
   endtask

   task automatic rd(input int unsigned k);
      address_i = addr_of(k); rd_wr_i = 1'b0;
      step();
      address_i = IDLE;
   endtask

   initial begin
      logic [DW-1:0] v, prev;
      logic          exp3;
      int            n;
      reset_i = 1'b0; rd_wr_i = 1'b0; address_i = IDLE; data_i = '0; raw_i = '0;
      model_clear();
      step(); step();
      reset_i = 1'b1;
      check("rst_clean", clean_o, 0);
      rd(0); check("rst_period", data_o, 4); check("rst_rd_hit0", take_controlr_o, 1);
      rd(1); check("rst_bypass", data_o, 0); check("rst_rd_hit1", take_controlr_o, 1);

      // stable rising edge on bit 0
      raw_i = 8'h01;
      for (int e = 1; e <= 6; e++) begin
         step();
         if (e == 5) check("edge5_bit0", clean_o[0], 0);
         if (e == 6) check("edge6_bit0", clean_o[0], 1);
      end
      rd(3); check("clean_reg", data_o, 8'h01);

      // glitch shorter than the period, then a qualifying pulse
      raw_i[1] = 1'b1; repeat (3) step();
      raw_i[1] = 1'b0; repeat (8) step();
      check("glitch_rejected", clean_o[1], 0);
      raw_i[1] = 1'b1; repeat (6) step();
      check("pulse_accepted", clean_o[1], 1);

      // bypass on bit 7
      wr(1, 8'h80); check("wr_bypass_ack", take_controlw_o, 1);
      raw_i[7] = 1'b1;
      step(); step(); check("byp_edge2", clean_o[7], 0);
      step();         check("byp_edge3", clean_o[7], 1);
      wr(1, 8'h00);

      // Period = 0 passes every bit through
      wr(0, 8'h00);
      prev = raw_i; v = DW'($urandom);
      raw_i = v;
      step(); step(); check("p0_edge2", clean_o, prev);
      step();         check("p0_edge3", clean_o, v);
      wr(2, 8'hff); check("wr_ro_ignored", take_controlw_o, 0);
      wr(0, 8'd4);

      // reset in the middle of a count
      raw_i = (v ^ 8'h04) | 8'h10;
      repeat (4) step();
      reset_i = 1'b0; step();
      check("midrst_clean", clean_o, 0);
      reset_i = 1'b1;
      repeat (5) step(); check("requal_edge5", clean_o, 0);
      step();            check("requal_edge6", clean_o, raw_i);

      // shorten the period while a count is at 3
      wr(0, 8'd8);
      raw_i[3] = ~raw_i[3]; exp3 = raw_i[3];
      repeat (4) step();
      address_i = addr_of(0); data_i = 8'd2; rd_wr_i = 1'b1;
      step(); check("wr_mid_noflip", clean_o[3], !exp3);
      rd_wr_i = 1'b0; address_i = IDLE;
      step(); check("wr_mid_flip", clean_o[3], exp3);
      wr(0, 8'd4);

`ifdef INPUT_DEBOUNCE_CHANGE_EN
      reset_i = 1'b0; raw_i = '0; step(); step(); reset_i = 1'b1;
      raw_i = 8'h05;
      n = 0;
      while (change_o == '0 && n < 20) begin step(); n++; end
      check("chg_seen", change_o, 8'h05);
      check("chg_latency", n, 6);
      step(); check("chg_pulse_end", change_o, 0);
      rd(4); check("chg_flags", data_o, 8'h05);
      rd(4); check("chg_cleared", data_o, 8'h00);
`else
      n = 0;
      rd(0);
      rd(4); check("reg4_unmapped_data", data_o, 0); check("reg4_unmapped_hit", take_controlr_o, 0);
`endif

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         int unsigned r, k;
         reset_i = ($urandom % 500) != 0;
         for (int b = 0; b < DW; b++) if ($urandom % 10 == 0) raw_i[b] = ~raw_i[b];
         r = $urandom % 8;
         if (r < 3) begin
            k = $urandom % 3;
            rd_wr_i = 1'b1; address_i = addr_of(k);
            data_i = (k == 0) ? DW'($urandom % 6) : DW'($urandom);
         end else begin
            rd_wr_i = 1'b0;
            address_i = ($urandom % 7 == 6) ? AW'($urandom) : addr_of($urandom % 6);
         end
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
